// File: rtl/muldiv_sequencer.sv
// Sequential signed multiply/divide unit producing MIPS-style HI/LO results.
// One shift-add or restoring shift-subtract iteration per cycle; signs are applied in FIXUP.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_CALC  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [3:0] OP_MULT  = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  state_e               state_q;
  logic [5:0]           cnt_q;
  logic                 is_div_q;
  logic                 div_zero_q;
  logic                 q_neg_q;
  logic                 r_neg_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     mb_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [WIDTH-1:0]     hi_d;
  logic [WIDTH-1:0]     lo_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;

  logic                 accept_s;
  logic                 b_zero_s;
  logic [WIDTH-1:0]     ma_s;
  logic [WIDTH-1:0]     mb_s;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       rem_sh_s;
  logic [WIDTH:0]       diff_s;
  logic [2*WIDTH-1:0]   prod_s;

  assign accept_s = start && ((alu_operation == OP_MULT) || (alu_operation == OP_DIV));
  assign b_zero_s = (b_q == {WIDTH{1'b0}});
  assign ma_s     = a_q[WIDTH-1] ? -a_q : a_q;
  assign mb_s     = b_q[WIDTH-1] ? -b_q : b_q;

  // Hold request: busy states, or an issuing muldiv in IDLE; never while reset is asserted.
  assign stall = rst_n && ((state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIXUP) ||
                           ((state_q == S_IDLE) && accept_s));

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    sum_s    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mb_q};
    rem_sh_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, mb_q};
    acc_d    = acc_q;
    if (is_div_q) begin
      if (rem_sh_s >= {1'b0, mb_q}) begin
        acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_d = {sum_s, acc_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  // Sign application; the overflow case falls out naturally because 0x80000000 negates to itself.
  always_comb begin
    prod_s = q_neg_q ? -acc_q : acc_q;
    hi_d   = prod_s[2*WIDTH-1:WIDTH];
    lo_d   = prod_s[WIDTH-1:0];
    if (div_zero_q) begin
      hi_d = a_q;
      lo_d = {WIDTH{1'b1}};
    end else if (is_div_q) begin
      hi_d = r_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      lo_d = q_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end else begin
      hi_d = prod_s[2*WIDTH-1:WIDTH];
      lo_d = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM with registered status outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      mb_q       <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            a_q      <= a;
            b_q      <= b;
            is_div_q <= (alu_operation == OP_DIV);
            busy_q   <= 1'b1;
            state_q  <= S_PREP;
          end
        end
        S_PREP: begin
          cnt_q      <= 6'd0;
          mb_q       <= mb_s;
          acc_q      <= {{WIDTH{1'b0}}, ma_s};
          q_neg_q    <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          r_neg_q    <= a_q[WIDTH-1];
          div_zero_q <= is_div_q && b_zero_s;
          state_q    <= (is_div_q && b_zero_s) ? S_FIXUP : S_CALC;
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          dbz_q   <= div_zero_q;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with hand-computed HI/LO results.
// Edge counts are taken after the accepting edge, so done on the 34th following edge is the 35th edge overall.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_operation;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_err = 0;
  int n_chk = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .alu_operation (alu_operation),
    .a             (a),
    .b             (b),
    .busy          (busy),
    .stall         (stall),
    .done          (done),
    .hi            (hi),
    .lo            (lo),
    .div_by_zero   (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one issue strobe; returns stall seen before the edge. Operands are scrambled after acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       output logic stall_seen);
    start = 1'b1;
    alu_operation = op;
    a = av;
    b = bv;
    #1;
    stall_seen = stall;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Waits for done (bounded); optionally injects a DIV start in CALC after edge inj.
  task automatic run_op(input int inj, output int edges, output int busy_n);
    edges = 0;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && edges < 100) begin
      if (edges == inj) begin
        start = 1'b1;
        alu_operation = 4'd13;
        a = 32'd1;
        b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
      if (busy === 1'b1) busy_n++;
    end
    start = 1'b0;
  endtask

  initial begin
    logic st;
    int   edges;
    int   busy_n;
    int   done_seen;

    rst_n = 1'b0;
    start = 1'b1;
    alu_operation = 4'd12;
    a = 32'd7;
    b = 32'd9;
    #12;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MULT 7 * -3 = -21
    issue(4'd12, 32'd7, 32'hFFFF_FFFD, st);
    chk("mult1_stall", {31'd0, st}, 32'd1);
    run_op(-1, edges, busy_n);
    chk("mult1_latency", edges, 32'd34);
    chk("mult1_busy_cycles", busy_n, 32'd35);
    chk("mult1_hi", hi, 32'hFFFF_FFFF);
    chk("mult1_lo", lo, 32'hFFFF_FFEB);
    chk("mult1_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;
    chk("mult1_done_drop", {31'd0, done}, 32'd0);
    chk("mult1_busy_drop", {31'd0, busy}, 32'd0);

    // DIV -7 / 2 -> q=-3, r=-1
    issue(4'd13, 32'hFFFF_FFF9, 32'd2, st);
    run_op(-1, edges, busy_n);
    chk("div1_latency", edges, 32'd34);
    chk("div1_lo", lo, 32'hFFFF_FFFD);
    chk("div1_hi", hi, 32'hFFFF_FFFF);
    chk("div1_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;

    // DIV 5 / 0
    issue(4'd13, 32'd5, 32'd0, st);
    run_op(-1, edges, busy_n);
    chk("dbz_latency", edges, 32'd2);
    chk("dbz_hi", hi, 32'd5);
    chk("dbz_lo", lo, 32'hFFFF_FFFF);
    chk("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    @(posedge clk);
    #1;
    chk("dbz_flag_drop", {31'd0, div_by_zero}, 32'd0);

    // Overflow divide, then most-negative squared
    issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, st);
    run_op(-1, edges, busy_n);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;
    issue(4'd12, 32'h8000_0000, 32'h8000_0000, st);
    run_op(-1, edges, busy_n);
    chk("minsq_hi", hi, 32'h4000_0000);
    chk("minsq_lo", lo, 32'd0);

    // Start in DONE cycle is ignored
    start = 1'b1;
    alu_operation = 4'd13;
    a = 32'd9;
    b = 32'd0;
    #1;
    chk("done_cycle_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_cycle_ignored", {31'd0, busy}, 32'd0);
    chk("done_cycle_hi_hold", hi, 32'h4000_0000);

    // MULT 0x12345 * 0x100 with a DIV start injected mid-CALC
    issue(4'd12, 32'h0001_2345, 32'h0000_0100, st);
    run_op(10, edges, busy_n);
    chk("inj_latency", edges, 32'd34);
    chk("inj_hi", hi, 32'd0);
    chk("inj_lo", lo, 32'h0123_4500);
    chk("inj_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b1;
    alu_operation = 4'd8;
    a = 32'd3;
    b = 32'd3;
    #1;
    chk("op8_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("op8_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("op8_hi_hold", hi, 32'd0);
    chk("op8_lo_hold", lo, 32'h0123_4500);

    // Reset during CALC iteration 16
    issue(4'd12, 32'd100, 32'd200, st);
    repeat (17) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    chk("abort_no_done", done_seen, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    issue(4'd12, 32'd3, 32'd4, st);
    run_op(-1, edges, busy_n);
    chk("post_rst_latency", edges, 32'd34);
    chk("post_rst_lo", lo, 32'd12);
    chk("post_rst_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
